// File: rtl/core_data_router_pkg.sv
// rtl/core_data_router_pkg.sv - shared core data port types, address map and target encoding
package core_data_router_pkg;

    localparam logic [31:0] L1_START_ADDR = 32'h1000_0000;
    localparam logic [31:0] L1_END_ADDR   = 32'h2000_0000;
    localparam logic [31:0] L2_START_ADDR = 32'h2000_0000;
    localparam logic [31:0] L2_END_ADDR   = 32'h3000_0000;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [5:0]  atop;
        logic [3:0]  be;
        logic [1:0]  memtype;
        logic [2:0]  prot;
        logic        dbg;
        logic [31:0] wdata;
        logic        we;
    } core_data_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
        logic        exokay;
    } core_data_rsp_t;

    typedef enum logic [1:0] {
        TGT_IDLE = 2'd0,
        TGT_L1   = 2'd1,
        TGT_L2   = 2'd2,
        TGT_ERR  = 2'd3
    } core_data_tgt_e;

    // Half-open window: lo inclusive, hi exclusive.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (addr >= lo) && (addr < hi);
    endfunction

endpackage

// File: rtl/core_data_err_slave.sv
// rtl/core_data_err_slave.sv - always-grant error responder with a queue of pending error responses
module core_data_err_slave
    import core_data_router_pkg::*;
#(
    parameter int unsigned N_MAX_TRAN = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic accept_i,
    output logic rvalid_o
);

    localparam int unsigned CW = $clog2(N_MAX_TRAN + 1);

    logic [CW-1:0] pend_q, pend_d;

    assign rvalid_o = (pend_q != '0);

    // One error response leaves per cycle while any are queued; a same-cycle
    // accept keeps the queue depth (and thus err_pend) unchanged.
    always_comb begin
        pend_d = pend_q;
        if (accept_i && !rvalid_o) begin
            pend_d = pend_q + CW'(1);
        end else if (!accept_i && rvalid_o) begin
            pend_d = pend_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/core_data_router.sv
// rtl/core_data_router.sv - routes core data requests to L1, L2 or the error responder, keeping responses in order
module core_data_router
    import core_data_router_pkg::*;
#(
    parameter int unsigned N_MAX_TRAN = 1,
    parameter logic [31:0] L1_START   = L1_START_ADDR,
    parameter logic [31:0] L1_END     = L1_END_ADDR,
    parameter logic [31:0] L2_START   = L2_START_ADDR,
    parameter logic [31:0] L2_END     = L2_END_ADDR
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  core_data_req_t core_req_i,
    output core_data_rsp_t core_rsp_o,
    output core_data_req_t l1_req_o,
    input  core_data_rsp_t l1_rsp_i,
    output core_data_req_t l2_req_o,
    input  core_data_rsp_t l2_rsp_i,
    output logic           busy_o
);

    localparam int unsigned   CW      = $clog2(N_MAX_TRAN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(N_MAX_TRAN);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0]  cnt_q, cnt_d;
    core_data_tgt_e sel_q, sel_d;
    core_data_tgt_e tgt;
    logic           issue_ok;
    logic           tgt_gnt;
    logic           accept;
    logic           rsp_fire;
    logic           err_accept;
    logic           err_rvalid;
    logic           stray;

    // L1 has no atomic support, so atomics into the L1 window go to the error responder.
    always_comb begin
        tgt = TGT_ERR;
        if (in_window(core_req_i.addr, L1_START, L1_END)) begin
            tgt = (core_req_i.atop != '0) ? TGT_ERR : TGT_L1;
        end else if (in_window(core_req_i.addr, L2_START, L2_END)) begin
            tgt = TGT_L2;
        end
    end

    always_comb begin
        core_rsp_o = '0;
        l1_req_o   = '0;
        l2_req_o   = '0;
        tgt_gnt    = 1'b0;

        unique case (sel_q)
            TGT_L1: begin
                core_rsp_o.rvalid = l1_rsp_i.rvalid;
                core_rsp_o.rdata  = l1_rsp_i.rdata;
                core_rsp_o.err    = l1_rsp_i.err;
                core_rsp_o.exokay = l1_rsp_i.exokay;
            end
            TGT_L2: begin
                core_rsp_o.rvalid = l2_rsp_i.rvalid;
                core_rsp_o.rdata  = l2_rsp_i.rdata;
                core_rsp_o.err    = l2_rsp_i.err;
                core_rsp_o.exokay = l2_rsp_i.exokay;
            end
            TGT_ERR: begin
                core_rsp_o.rvalid = err_rvalid;
                core_rsp_o.err    = 1'b1;
            end
            default: ;
        endcase
        rsp_fire = core_rsp_o.rvalid;

        // A response retiring this cycle frees its slot, so the next request
        // (even to another target when it was the last one) issues with no bubble.
        issue_ok = ((cnt_q < CNT_MAX) || rsp_fire)
                && ((cnt_q == '0) || (tgt == sel_q) || ((cnt_q == CNT_ONE) && rsp_fire));

        unique case (tgt)
            TGT_L1:  tgt_gnt = l1_rsp_i.gnt;
            TGT_L2:  tgt_gnt = l2_rsp_i.gnt;
            TGT_ERR: tgt_gnt = 1'b1;
            default: tgt_gnt = 1'b0;
        endcase

        core_rsp_o.gnt = core_req_i.req && issue_ok && tgt_gnt;
        accept         = core_rsp_o.gnt;
        err_accept     = accept && (tgt == TGT_ERR);

        if (tgt == TGT_L1) begin
            l1_req_o     = core_req_i;
            l1_req_o.req = core_req_i.req && issue_ok;
        end
        if (tgt == TGT_L2) begin
            l2_req_o     = core_req_i;
            l2_req_o.req = core_req_i.req && issue_ok;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !rsp_fire) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!accept && rsp_fire) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        sel_d = sel_q;
        if (accept && ((cnt_q == '0) || ((cnt_q == CNT_ONE) && rsp_fire))) begin
            sel_d = tgt;
        end else if (cnt_d == '0) begin
            sel_d = TGT_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sel_q <= TGT_IDLE;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

    core_data_err_slave #(
        .N_MAX_TRAN (N_MAX_TRAN)
    ) u_err_slave (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .accept_i (err_accept),
        .rvalid_o (err_rvalid)
    );

    assign busy_o = (cnt_q != '0);
    assign stray  = (l1_rsp_i.rvalid && (sel_q != TGT_L1))
                 || (l2_rsp_i.rvalid && (sel_q != TGT_L2));

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(rsp_fire && (cnt_q == '0)))
                else $error("core_data_router: outstanding count underflow");
            assert (!stray)
                else $warning("core_data_router: stray target response dropped");
        end
    end

endmodule

// File: tb/tb_core_data_router.sv
// tb/tb_core_data_router.sv - directed scoreboard bench for core_data_router (N_MAX_TRAN 1 and 4)
module tb_core_data_router;
    import core_data_router_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;

    core_data_req_t req1, l1q1, l2q1, req4, l1q4, l2q4;
    core_data_rsp_t rsp1, l1r1, l2r1, rsp4, l1r4, l2r4;
    logic           busy1, busy4;

    exp_t sb1[$];
    exp_t sb4[$];
    int   total;
    int   bad;

    core_data_router #(.N_MAX_TRAN(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .core_req_i(req1), .core_rsp_o(rsp1),
        .l1_req_o(l1q1), .l1_rsp_i(l1r1),
        .l2_req_o(l2q1), .l2_rsp_i(l2r1),
        .busy_o(busy1)
    );

    core_data_router #(.N_MAX_TRAN(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .core_req_i(req4), .core_rsp_o(rsp4),
        .l1_req_o(l1q4), .l1_rsp_i(l1r4),
        .l2_req_o(l2q4), .l2_rsp_i(l2r4),
        .busy_o(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic core_data_req_t mk_req(input logic [31:0] a, input logic we, input logic [5:0] atop);
        core_data_req_t r;
        r       = '0;
        r.req   = 1'b1;
        r.addr  = a;
        r.we    = we;
        r.atop  = atop;
        r.be    = 4'hF;
        r.wdata = a ^ 32'h5555_0000;
        return r;
    endfunction

    function automatic core_data_rsp_t mk_rsp(input logic gnt, input logic rvalid, input logic [31:0] rdata);
        core_data_rsp_t r;
        r        = '0;
        r.gnt    = gnt;
        r.rvalid = rvalid;
        r.rdata  = rdata;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
            else begin
                bad++;
                $error("FAIL %s: got %h want %h", tag, obs, exp_v);
            end
    endtask

    task automatic sb_check(input string tag, input core_data_rsp_t rsp, inout exp_t q[$]);
        exp_t e;
        if (rsp.rvalid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL %s_extra: got rvalid with rdata %h, want no response", tag, rsp.rdata);
            end else begin
                e = q.pop_front();
                chk({tag, "_rdata"}, rsp.rdata, e.rdata);
                chk({tag, "_err"}, {31'd0, rsp.err}, {31'd0, e.err});
            end
        end
    endtask

    // Scoreboard compare at the falling edge, then advance to just past the next rising edge.
    task automatic tick();
        @(negedge clk);
        sb_check("sb1", rsp1, sb1);
        sb_check("sb4", rsp4, sb4);
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req1 = '0; l1r1 = '0; l2r1 = '0;
        req4 = '0; l1r4 = '0; l2r4 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy1", busy1, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_rvalid1", rsp1.rvalid, 0);
        chk("rst_gnt1", rsp1.gnt, 0);
        rst_n = 1'b1;
        tick();

        // L1 read
        req1 = mk_req(32'h1000_0040, 1'b0, 6'h0);
        l1r1 = mk_rsp(1'b1, 1'b0, 32'h0);
        #1;
        chk("l1rd_l1req", l1q1.req, 1);
        chk("l1rd_addr", l1q1.addr, 32'h1000_0040);
        chk("l1rd_l2req", l2q1.req, 0);
        chk("l1rd_gnt", rsp1.gnt, 1);
        chk("l1rd_busy_c0", busy1, 0);
        sb1.push_back(exp_t'{rdata: 32'hDEAD_BEEF, err: 1'b0});
        tick();
        req1 = '0;
        l1r1 = mk_rsp(1'b0, 1'b1, 32'hDEAD_BEEF);
        #1;
        chk("l1rd_rvalid", rsp1.rvalid, 1);
        chk("l1rd_busy_c1", busy1, 1);
        chk("l1rd_l2req_c1", l2q1.req, 0);
        tick();
        l1r1 = '0;
        #1;
        chk("l1rd_busy_c2", busy1, 0);

        // L2 write then L1 read held off until the L2 response
        req1 = mk_req(32'h2000_0000, 1'b1, 6'h0);
        l2r1 = mk_rsp(1'b1, 1'b0, 32'h0);
        #1;
        chk("b2b_l2gnt", rsp1.gnt, 1);
        chk("b2b_l2req", l2q1.req, 1);
        chk("b2b_l2we", l2q1.we, 1);
        sb1.push_back(exp_t'{rdata: 32'h0, err: 1'b0});
        tick();
        req1 = mk_req(32'h1000_0000, 1'b0, 6'h0);
        l1r1 = mk_rsp(1'b1, 1'b0, 32'h0);
        l2r1 = '0;
        #1;
        chk("b2b_hold_req", l1q1.req, 0);
        chk("b2b_hold_gnt", rsp1.gnt, 0);
        tick();
        l2r1 = mk_rsp(1'b0, 1'b1, 32'h0);
        #1;
        chk("b2b_issue_req", l1q1.req, 1);
        chk("b2b_issue_gnt", rsp1.gnt, 1);
        chk("b2b_l2_rvalid", rsp1.rvalid, 1);
        sb1.push_back(exp_t'{rdata: 32'h1234_5678, err: 1'b0});
        tick();
        req1 = '0;
        l2r1 = '0;
        l1r1 = mk_rsp(1'b0, 1'b1, 32'h1234_5678);
        #1;
        chk("b2b_l1_rvalid", rsp1.rvalid, 1);
        tick();
        l1r1 = '0;
        #1;
        chk("b2b_busy_end", busy1, 0);

        // Unmapped and atomic errors
        for (int k = 0; k < 2; k++) begin
            req1 = (k == 0) ? mk_req(32'h3000_0000, 1'b0, 6'h0) : mk_req(32'h1000_0000, 1'b1, 6'h21);
            #1;
            chk("err_gnt", rsp1.gnt, 1);
            chk("err_l1req", l1q1.req, 0);
            chk("err_l2req", l2q1.req, 0);
            sb1.push_back(exp_t'{rdata: 32'h0, err: 1'b1});
            tick();
            req1 = '0;
            #1;
            chk("err_rvalid", rsp1.rvalid, 1);
            chk("err_exokay", rsp1.exokay, 0);
            tick();
            chk("err_busy_end", busy1, 0);
        end

        // L1 grant withheld for three cycles
        req1 = mk_req(32'h1000_0100, 1'b0, 6'h0);
        l1r1 = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_req", l1q1.req, 1);
            chk("stall_addr", l1q1.addr, 32'h1000_0100);
            chk("stall_gnt", rsp1.gnt, 0);
            tick();
            chk("stall_busy", busy1, 0);
        end
        l1r1 = mk_rsp(1'b1, 1'b0, 32'h0);
        #1;
        chk("stall_gnt_final", rsp1.gnt, 1);
        sb1.push_back(exp_t'{rdata: 32'hCAFE_F00D, err: 1'b0});
        tick();
        req1 = '0;
        l1r1 = mk_rsp(1'b0, 1'b1, 32'hCAFE_F00D);
        #1;
        chk("stall_busy_after", busy1, 1);
        tick();
        l1r1 = '0;

        // Pipelining on the N_MAX_TRAN=4 instance
        l2r4 = mk_rsp(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            req4 = mk_req(32'h2000_0000 + 32'(4 * k), 1'b0, 6'h0);
            #1;
            chk("pipe_gnt", rsp4.gnt, 1);
            sb4.push_back(exp_t'{rdata: 32'hA000_0000 + 32'(k), err: 1'b0});
            tick();
        end
        req4 = mk_req(32'h2000_0010, 1'b0, 6'h0);
        #1;
        chk("pipe_full_gnt", rsp4.gnt, 0);
        chk("pipe_full_req", l2q4.req, 0);
        tick();
        l2r4 = mk_rsp(1'b1, 1'b1, 32'hA000_0000);
        #1;
        chk("pipe_swap_gnt", rsp4.gnt, 1);
        sb4.push_back(exp_t'{rdata: 32'hA000_0004, err: 1'b0});
        tick();
        req4 = mk_req(32'h2000_0014, 1'b0, 6'h0);
        l2r4 = mk_rsp(1'b1, 1'b0, 32'h0);
        #1;
        chk("pipe_still_full", rsp4.gnt, 0);
        tick();
        req4 = '0;
        for (int k = 1; k <= 4; k++) begin
            l2r4 = mk_rsp(1'b0, 1'b1, 32'hA000_0000 + 32'(k));
            tick();
        end
        l2r4 = '0;
        #1;
        chk("pipe_busy_end", busy4, 0);

        // Back-to-back error responses
        req4 = mk_req(32'h0000_0100, 1'b0, 6'h0);
        #1;
        chk("err2_gnt0", rsp4.gnt, 1);
        sb4.push_back(exp_t'{rdata: 32'h0, err: 1'b1});
        tick();
        #1;
        chk("err2_gnt1", rsp4.gnt, 1);
        chk("err2_rv1", rsp4.rvalid, 1);
        sb4.push_back(exp_t'{rdata: 32'h0, err: 1'b1});
        tick();
        req4 = '0;
        #1;
        chk("err2_rv2", rsp4.rvalid, 1);
        tick();
        chk("err2_rv3", rsp4.rvalid, 0);
        chk("err2_busy", busy4, 0);

        // Reset with two outstanding, then a stray L1 response
        l2r4 = mk_rsp(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            req4 = mk_req(32'h2000_0100 + 32'(4 * k), 1'b0, 6'h0);
            #1;
            chk("rstm_gnt", rsp4.gnt, 1);
            sb4.push_back(exp_t'{rdata: 32'h0, err: 1'b0});
            tick();
        end
        req4 = '0;
        l2r4 = '0;
        #1;
        chk("rstm_busy_before", busy4, 1);
        rst_n = 1'b0;
        #1;
        chk("rstm_busy_async", busy4, 0);
        sb4.delete();
        tick();
        rst_n = 1'b1;
        l1r4 = mk_rsp(1'b0, 1'b1, 32'h0000_0BAD);
        #1;
        chk("stray_rvalid", rsp4.rvalid, 0);
        chk("stray_busy", busy4, 0);
        tick();
        l1r4 = '0;
        tick();

        chk("sb1_empty", sb1.size(), 0);
        chk("sb4_empty", sb4.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
